// File: rtl/log_seq_pkg.sv
// log_seq_pkg: shared constants for the log capture sequencer.
//   - command opcodes carried on GPIO [31:24]
//   - sequencer FSM state encodings
//   - logged-source select codes
package log_seq_pkg;

   localparam int unsigned OPCODE_W = 8;
   localparam int unsigned PAYLOAD_W = 16;
   localparam int unsigned SEL_W = 3;

   localparam logic [OPCODE_W-1:0] OP_START     = 8'h03;
   localparam logic [OPCODE_W-1:0] OP_SET_RADDR = 8'h04;
   localparam logic [OPCODE_W-1:0] OP_ABORT     = 8'h07;
   localparam logic [OPCODE_W-1:0] OP_INC_RADDR = 8'h08;

   localparam logic [SEL_W-1:0] SEL_FSE_IN    = 3'd0;
   localparam logic [SEL_W-1:0] SEL_SLICER_IN = 3'd1;
   localparam logic [SEL_W-1:0] SEL_COEFF     = 3'd2;
   localparam logic [SEL_W-1:0] SEL_ERROR     = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/log_cmd_decoder.sv
// log_cmd_decoder: rising-edge detect on the GPIO command strobe and opcode
// decode into single-cycle command pulses.
// Ports:
//   clk, w_reset        clock, synchronous active-high reset
//   i_cmd_valid         command strobe (level, may be held high)
//   i_cmd_opcode        command opcode
//   i_cmd_sel           payload[2:0], start source select
//   o_start_c .. o_inc_raddr_c  combinational command pulses, one per strobe edge
//   o_sel_c             select value accompanying a start
module log_cmd_decoder
   import log_seq_pkg::*;
(
   input  logic                clk,
   input  logic                w_reset,
   input  logic                i_cmd_valid,
   input  logic [OPCODE_W-1:0] i_cmd_opcode,
   input  logic [SEL_W-1:0]    i_cmd_sel,
   output logic                o_start_c,
   output logic                o_abort_c,
   output logic                o_set_raddr_c,
   output logic                o_inc_raddr_c,
   output logic [SEL_W-1:0]    o_sel_c
);

   logic cmd_valid_q;
   logic cmd_valid_d;
   logic accept_c;

   // Previous strobe level for edge detection
   always_comb cmd_valid_d = i_cmd_valid;

   always_ff @(posedge clk) begin
      if (w_reset) cmd_valid_q <= 1'b0;
      else         cmd_valid_q <= cmd_valid_d;
   end

   // Decode only on the first high cycle of the strobe
   always_comb begin
      accept_c      = i_cmd_valid & ~cmd_valid_q;
      o_start_c     = 1'b0;
      o_abort_c     = 1'b0;
      o_set_raddr_c = 1'b0;
      o_inc_raddr_c = 1'b0;
      o_sel_c       = i_cmd_sel;
      if (accept_c) begin
         case (i_cmd_opcode)
            OP_START:     o_start_c     = 1'b1;
            OP_ABORT:     o_abort_c     = 1'b1;
            OP_SET_RADDR: o_set_raddr_c = 1'b1;
            OP_INC_RADDR: o_inc_raddr_c = 1'b1;
            default:      ;
         endcase
      end
   end

endmodule

// File: rtl/log_capture_sequencer.sv
// log_capture_sequencer: GPIO-commanded capture sequencer that streams one
// selected signal source into a log RAM at its sample-strobe rate, plus a
// host-controlled RAM read pointer and a status readback word.
// Configuration: define LOG_TRIGGER_EN to add i_trigger and hold ARM until
// the trigger is seen; default build passes ARM -> CAPT after one cycle.
// Ports:
//   clk, w_reset                 clock, synchronous active-high reset
//   i_cmd_valid/opcode/payload   GPIO command interface
//   i_rate_two, i_rate_one       2xBR and 1xBR sample strobes
//   i_trigger                    capture trigger (LOG_TRIGGER_EN only)
//   o_ram_we, o_ram_waddr        log RAM write port
//   o_ram_raddr                  log RAM read address
//   o_data_sel                   logged-source select
//   o_busy, o_done               capture in progress / complete
//   o_status                     {state, done, err, 0, full, count}
module log_capture_sequencer
   import log_seq_pkg::*;
#(
   parameter int unsigned RAM_ADDR_W = 15,
   parameter int unsigned NBT_GPIOS  = 32
) (
   input  logic                  clk,
   input  logic                  w_reset,
   input  logic                  i_cmd_valid,
   input  logic [OPCODE_W-1:0]   i_cmd_opcode,
   input  logic [PAYLOAD_W-1:0]  i_cmd_payload,
   input  logic                  i_rate_two,
   input  logic                  i_rate_one,
`ifdef LOG_TRIGGER_EN
   input  logic                  i_trigger,
`endif
   output logic                  o_ram_we,
   output logic [RAM_ADDR_W-1:0] o_ram_waddr,
   output logic [RAM_ADDR_W-1:0] o_ram_raddr,
   output logic [SEL_W-1:0]      o_data_sel,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [NBT_GPIOS-1:0]  o_status
);

   // Count needs one extra bit so a full RAM reads back as depth
   localparam int unsigned CNT_W = RAM_ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH = {1'b1, {RAM_ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] LAST  = {1'b0, {RAM_ADDR_W{1'b1}}};

   logic start_c;
   logic abort_c;
   logic set_raddr_c;
   logic inc_raddr_c;
   logic [SEL_W-1:0] sel_c;
   logic strobe_c;
   logic arm_go_c;
   logic full_c;
   logic [31:0] status_word_c;

   seq_state_e            state_q,     state_d;
   logic [CNT_W-1:0]      count_q,     count_d;
   logic [RAM_ADDR_W-1:0] raddr_q,     raddr_d;
   logic [SEL_W-1:0]      data_sel_q,  data_sel_d;
   logic                  err_q,       err_d;
   logic                  ram_we_q,    ram_we_d;
   logic [RAM_ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
   logic                  busy_q,      busy_d;
   logic                  done_q,      done_d;
   logic [NBT_GPIOS-1:0]  status_q,    status_d;

   log_cmd_decoder u_cmd_decoder (
      .clk           (clk),
      .w_reset       (w_reset),
      .i_cmd_valid   (i_cmd_valid),
      .i_cmd_opcode  (i_cmd_opcode),
      .i_cmd_sel     (i_cmd_payload[SEL_W-1:0]),
      .o_start_c     (start_c),
      .o_abort_c     (abort_c),
      .o_set_raddr_c (set_raddr_c),
      .o_inc_raddr_c (inc_raddr_c),
      .o_sel_c       (sel_c)
   );

   // Coefficient and error sources run at 1xBR, the others at 2xBR
   always_comb begin
      strobe_c = ((data_sel_q == SEL_COEFF) || (data_sel_q == SEL_ERROR)) ?
                 i_rate_one : i_rate_two;
   end

`ifdef LOG_TRIGGER_EN
   always_comb arm_go_c = i_trigger;
`else
   always_comb arm_go_c = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (w_reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         raddr_q     <= '0;
         data_sel_q  <= '0;
         err_q       <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_waddr_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         status_q    <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         raddr_q     <= raddr_d;
         data_sel_q  <= data_sel_d;
         err_q       <= err_d;
         ram_we_q    <= ram_we_d;
         ram_waddr_q <= ram_waddr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         status_q    <= status_d;
      end
   end

   // Next-state, capture counter, read pointer and status
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      raddr_d     = raddr_q;
      data_sel_d  = data_sel_q;
      err_d       = err_q;
      ram_we_d    = 1'b0;
      ram_waddr_d = ram_waddr_q;
      done_d      = done_q;

      // Read pointer is independent of the capture FSM
      if (set_raddr_c) begin
         raddr_d = RAM_ADDR_W'(i_cmd_payload);
      end else if (inc_raddr_c) begin
         raddr_d = raddr_q + RAM_ADDR_W'(1);
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (abort_c && (state_q == ST_DONE)) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end else if (start_c) begin
               if (sel_c[2]) begin
                  err_d = 1'b1;
               end else begin
                  data_sel_d = sel_c;
                  count_d    = '0;
                  done_d     = 1'b0;
                  err_d      = 1'b0;
                  state_d    = ST_ARM;
               end
            end
         end
         ST_ARM: begin
            if (abort_c) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end else if (arm_go_c) begin
               state_d = ST_CAPT;
            end
         end
         ST_CAPT: begin
            // Abort takes priority over a coinciding strobe
            if (abort_c) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end else if (strobe_c) begin
               ram_we_d    = 1'b1;
               ram_waddr_d = RAM_ADDR_W'(count_q);
               count_d     = count_q + CNT_W'(1);
               if (count_q == LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d        = (state_d == ST_ARM) || (state_d == ST_CAPT);
      full_c        = (count_d == DEPTH);
      status_word_c = {state_d, done_d, err_d, 12'd0, full_c, 15'(count_d)};
      status_d      = NBT_GPIOS'(status_word_c);
   end

   assign o_ram_we    = ram_we_q;
   assign o_ram_waddr = ram_waddr_q;
   assign o_ram_raddr = raddr_q;
   assign o_data_sel  = data_sel_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_status    = status_q;

endmodule
